// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter sharing the register file's single write port among NREQ requesters.
// The winning write is registered into a one-entry output stage; writes to ZERO_REG are dropped.
module regfile_write_arbiter #(
  parameter int unsigned NREQ       = 3,
  parameter int unsigned DATA_WIDTH = 64,
  parameter logic [4:0]  ZERO_REG   = 5'd31
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic [NREQ-1:0]            req_valid,
  input  logic [NREQ*5-1:0]          req_addr,
  input  logic [NREQ*DATA_WIDTH-1:0] req_data,
  output logic [NREQ-1:0]            req_ready,
  input  logic                       wr_stall,
  output logic                       wr_en,
  output logic [4:0]                 wr_addr,
  output logic [DATA_WIDTH-1:0]      wr_data,
  output logic [7:0]                 drop_count
);

  localparam int unsigned PtrW = $clog2(NREQ);

  logic [PtrW-1:0]       ptr_q, ptr_d;
  logic                  wr_en_q, wr_en_d;
  logic [4:0]            wr_addr_q, wr_addr_d;
  logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
  logic [7:0]            drop_q, drop_d;

  logic [PtrW-1:0]       grant_idx;
  logic [PtrW-1:0]       cand;
  logic                  found;
  logic                  xfer;
  int                    idx;
  logic [4:0]            sel_addr;
  logic [DATA_WIDTH-1:0] sel_data;

  // Search starts just past the last winner and wraps; first valid requester wins.
  always_comb begin
    grant_idx = ptr_q;
    cand      = ptr_q;
    found     = 1'b0;
    idx       = 0;
    for (int k = 1; k <= int'(NREQ); k++) begin
      idx  = (int'(ptr_q) + k) % int'(NREQ);
      cand = PtrW'(idx);
      if (!found && req_valid[cand]) begin
        found     = 1'b1;
        grant_idx = cand;
      end
    end
    xfer      = found && !wr_stall && reset_n;
    req_ready = '0;
    if (xfer) begin
      req_ready[grant_idx] = 1'b1;
    end
  end

  assign sel_addr = req_addr[int'(grant_idx)*5 +: 5];
  assign sel_data = req_data[int'(grant_idx)*DATA_WIDTH +: DATA_WIDTH];

  always_comb begin
    ptr_d     = ptr_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    drop_d    = drop_q;
    if (xfer) begin
      ptr_d = grant_idx;
      if (sel_addr == ZERO_REG) begin
        if (drop_q != 8'hFF) begin
          drop_d = drop_q + 8'd1;
        end
      end else begin
        wr_en_d   = 1'b1;
        wr_addr_d = sel_addr;
        wr_data_d = sel_data;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ptr_q     <= PtrW'(NREQ - 1);
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      drop_q    <= '0;
    end else begin
      ptr_q     <= ptr_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      drop_q    <= drop_d;
    end
  end

  assign wr_en      = wr_en_q;
  assign wr_addr    = wr_addr_q;
  assign wr_data    = wr_data_q;
  assign drop_count = drop_q;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed-vector bench for regfile_write_arbiter with NREQ=3, DATA_WIDTH=64.
module tb_regfile_write_arbiter;

  localparam int NREQ = 3;
  localparam int DW   = 64;

  logic              clk;
  logic              reset_n;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ*5-1:0] req_addr;
  logic [NREQ*DW-1:0] req_data;
  logic [NREQ-1:0]   req_ready;
  logic              wr_stall;
  logic              wr_en;
  logic [4:0]        wr_addr;
  logic [DW-1:0]     wr_data;
  logic [7:0]        drop_count;

  int total = 0;
  int bad   = 0;

  regfile_write_arbiter #(
    .NREQ(NREQ),
    .DATA_WIDTH(DW),
    .ZERO_REG(5'd31)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .req_valid(req_valid),
    .req_addr(req_addr),
    .req_data(req_data),
    .req_ready(req_ready),
    .wr_stall(wr_stall),
    .wr_en(wr_en),
    .wr_addr(wr_addr),
    .wr_data(wr_data),
    .drop_count(drop_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  valid;
    logic [14:0] addr;
    logic [47:0] data;
    logic        stall;
    logic [2:0]  ready;
    logic        en;
    logic [4:0]  waddr;
    logic [15:0] wdata;
    logic [7:0]  drop;
  } vec_t;

  localparam logic [14:0] ADEF = {5'd7, 5'd5, 5'd3};
  localparam logic [14:0] AZ   = {5'd31, 5'd5, 5'd3};
  localparam logic [47:0] DDEF = {16'h2222, 16'h00AB, 16'h1111};
  localparam logic [47:0] DZ   = {16'h3333, 16'h00AB, 16'h1111};

  vec_t tv [20];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [2:0] v, input logic [14:0] a, input logic [47:0] d,
                       input logic s);
    req_valid = v;
    req_addr  = a;
    for (int i = 0; i < NREQ; i++) begin
      req_data[i*DW +: DW] = 64'(d[i*16 +: 16]);
    end
    wr_stall = s;
  endtask

  initial begin
    // From reset ptr=2; expected values worked out by hand per cycle.
    tv[0]  = '{3'b010, ADEF, DDEF, 1'b0, 3'b010, 1'b1, 5'd5, 16'h00AB, 8'd0};
    tv[1]  = '{3'b010, ADEF, DDEF, 1'b0, 3'b010, 1'b1, 5'd5, 16'h00AB, 8'd0};
    tv[2]  = '{3'b111, ADEF, DDEF, 1'b0, 3'b100, 1'b1, 5'd7, 16'h2222, 8'd0};
    tv[3]  = '{3'b111, ADEF, DDEF, 1'b0, 3'b001, 1'b1, 5'd3, 16'h1111, 8'd0};
    tv[4]  = '{3'b111, ADEF, DDEF, 1'b0, 3'b010, 1'b1, 5'd5, 16'h00AB, 8'd0};
    tv[5]  = '{3'b111, ADEF, DDEF, 1'b0, 3'b100, 1'b1, 5'd7, 16'h2222, 8'd0};
    tv[6]  = '{3'b111, ADEF, DDEF, 1'b0, 3'b001, 1'b1, 5'd3, 16'h1111, 8'd0};
    tv[7]  = '{3'b111, ADEF, DDEF, 1'b1, 3'b000, 1'b0, 5'd3, 16'h1111, 8'd0};
    tv[8]  = '{3'b111, ADEF, DDEF, 1'b1, 3'b000, 1'b0, 5'd3, 16'h1111, 8'd0};
    tv[9]  = '{3'b111, ADEF, DDEF, 1'b1, 3'b000, 1'b0, 5'd3, 16'h1111, 8'd0};
    tv[10] = '{3'b111, ADEF, DDEF, 1'b0, 3'b010, 1'b1, 5'd5, 16'h00AB, 8'd0};
    tv[11] = '{3'b001, ADEF, DDEF, 1'b0, 3'b001, 1'b1, 5'd3, 16'h1111, 8'd0};
    tv[12] = '{3'b101, ADEF, DDEF, 1'b0, 3'b100, 1'b1, 5'd7, 16'h2222, 8'd0};
    tv[13] = '{3'b101, ADEF, DDEF, 1'b0, 3'b001, 1'b1, 5'd3, 16'h1111, 8'd0};
    tv[14] = '{3'b101, ADEF, DDEF, 1'b0, 3'b100, 1'b1, 5'd7, 16'h2222, 8'd0};
    tv[15] = '{3'b100, AZ,   DZ,   1'b0, 3'b100, 1'b0, 5'd7, 16'h2222, 8'd1};
    tv[16] = '{3'b000, AZ,   DZ,   1'b0, 3'b000, 1'b0, 5'd7, 16'h2222, 8'd1};
    tv[17] = '{3'b001, AZ,   DZ,   1'b0, 3'b001, 1'b1, 5'd3, 16'h1111, 8'd1};
    tv[18] = '{3'b100, AZ,   DZ,   1'b0, 3'b100, 1'b0, 5'd3, 16'h1111, 8'd2};
    // Zero-reg transfer moved ptr to 2, so requester 0 now beats requester 2.
    tv[19] = '{3'b101, AZ,   DZ,   1'b0, 3'b001, 1'b1, 5'd3, 16'h1111, 8'd2};

    reset_n = 1'b0;
    drive(3'b000, '0, '0, 1'b0);
    repeat (2) @(negedge clk);
    #1;
    chk("rst_ready", 64'(req_ready), 64'd0);
    chk("rst_wr_en", 64'(wr_en), 64'd0);
    chk("rst_drop", 64'(drop_count), 64'd0);
    reset_n = 1'b1;

    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      drive(tv[i].valid, tv[i].addr, tv[i].data, tv[i].stall);
      #1;
      chk($sformatf("v%0d ready", i), 64'(req_ready), 64'(tv[i].ready));
      @(posedge clk);
      #1;
      chk($sformatf("v%0d wr_en", i), 64'(wr_en), 64'(tv[i].en));
      chk($sformatf("v%0d wr_addr", i), 64'(wr_addr), 64'(tv[i].waddr));
      chk($sformatf("v%0d wr_data", i), wr_data, 64'(tv[i].wdata));
      chk($sformatf("v%0d drop", i), 64'(drop_count), 64'(tv[i].drop));
    end

    // 300 more zero-register writes: count saturates at 255.
    @(negedge clk);
    drive(3'b100, AZ, DZ, 1'b0);
    repeat (300) @(posedge clk);
    #1;
    chk("sat drop", 64'(drop_count), 64'd255);
    chk("sat wr_en", 64'(wr_en), 64'd0);
    chk("sat wr_addr", 64'(wr_addr), 64'd3);

    // Register a real write, then reset asynchronously while wr_en is high.
    @(negedge clk);
    drive(3'b010, ADEF, DDEF, 1'b0);
    @(posedge clk);
    #1;
    chk("pre_rst wr_en", 64'(wr_en), 64'd1);
    reset_n = 1'b0;
    #1;
    chk("async wr_en", 64'(wr_en), 64'd0);
    chk("async wr_addr", 64'(wr_addr), 64'd0);
    chk("async wr_data", wr_data, 64'd0);
    chk("async drop", 64'(drop_count), 64'd0);
    chk("async ready", 64'(req_ready), 64'd0);

    // After release requester 0 wins first, then rotation 1,2,0.
    @(negedge clk);
    reset_n = 1'b1;
    drive(3'b111, ADEF, DDEF, 1'b0);
    #1;
    chk("rel ready0", 64'(req_ready), 64'b001);
    @(posedge clk);
    #1;
    chk("rel addr0", 64'(wr_addr), 64'd3);
    @(negedge clk);
    chk("rel ready1", 64'(req_ready), 64'b010);
    @(posedge clk);
    #1;
    chk("rel addr1", 64'(wr_addr), 64'd5);
    @(negedge clk);
    chk("rel ready2", 64'(req_ready), 64'b100);
    @(posedge clk);
    #1;
    chk("rel addr2", 64'(wr_addr), 64'd7);
    chk("rel data2", wr_data, 64'h2222);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/regfile_write_arbiter.md
# regfile_write_arbiter

- Shares the register file's single write port (the 5-bit write-address decoder plus its write-enable) among NREQ writeback requesters. Requesters are, for example, ALU result, load data and BL link write.
- Accepts at most one write per cycle using a valid/ready handshake with round-robin priority.
- Registers the winning write into a one-entry output stage that drives the decoder's in/enable and the data bus.
- Writes to X31 (XZR) are consumed but never reach the register file.

## Interface

- NREQ, 3: number of requesters, 2..8.
- DATA_WIDTH, 64: write data width.
- ZERO_REG, 5'd31: address whose writes are suppressed.
- clk  input  1  rising-edge clock.
- reset_n  input  1  asynchronous, active-low reset. One clock; reset is asynchronous and active-low.
- req_valid  input  NREQ  requester i has a pending write.
- req_addr  input  NREQ*5  flattened; bits [5i+4:5i] are the destination for requester i.
- req_data  input  NREQ*DATA_WIDTH  flattened; slice i is the data for requester i.
- req_ready  output  NREQ  one-hot or zero; the grant. A transfer occurs when req_valid[i] and req_ready[i] are both high.
- wr_stall  input  1  register file cannot take a write this cycle.
- wr_en  output  1  decoder enable; registered.
- wr_addr  output  5  decoder in; registered.
- wr_data  output  DATA_WIDTH  registered write data.
- drop_count  output  8  saturating count of suppressed ZERO_REG writes.

## Operation

**Grant logic**
- Grant logic is combinational from req_valid, wr_stall and the round-robin pointer `ptr`. ptr is the index of the last granted requester.
- The search starts at (ptr+1) mod NREQ, then ascends with wrap-around. The first valid requester found gets req_ready.
- At most one req_ready bit is high.
- req_ready is all-zero when wr_stall=1, when no req_valid bit is set, or while reset_n=0.

**Pointer**
- ptr updates to the granted index only on a transfer. It is unchanged otherwise.
- Reset value: NREQ-1, so requester 0 wins first.

**Requester rules**
- Requesters hold valid, addr and data stable until transferred.
- A requester may drop valid without a transfer; the arbiter requires no memory of it.

**Output stage**, updated every clock:
- Transfer with addr != ZERO_REG: wr_en=1, wr_addr=addr, wr_data=data.
- Transfer with addr == ZERO_REG: wr_en=0; wr_addr and wr_data unchanged; drop_count increments, saturating at 255.
- No transfer: wr_en=0; wr_addr and wr_data keep their last values.

**Reset**
- wr_en=0, wr_addr=0, wr_data=0, drop_count=0, ptr=NREQ-1, req_ready=0.
- Reset asserted mid-operation clears everything immediately. A write registered but not yet consumed is lost; wr_en falls asynchronously.

**State machine:** none beyond ptr and the output register. The block is a single-stage pipelined arbiter.

## Timing

- Latency: a transfer in cycle N produces wr_en/wr_addr/wr_data in cycle N+1, held exactly one cycle.
- Throughput: one write per cycle while wr_stall=0.
- wr_stall is sampled in the same cycle as grant. Stall at N blocks the grant at N; it does not cancel a write already presented on wr_en at N.
- Fairness: with all NREQ requesters continuously valid, each is granted exactly once every NREQ cycles. Maximum wait is NREQ-1 granted cycles.
- Simultaneous events:
  - Stall plus valid: no grant, ptr held.
  - Single valid requester: granted every unstalled cycle, regardless of ptr.
  - A ZERO_REG transfer advances ptr like any other transfer.
- First transfer after reset release: no earlier than the first rising edge with reset_n=1.

## Test plan

- **Reset values:** assert reset_n=0 mid-stream with wr_en=1 -> wr_en, wr_addr, wr_data and drop_count read 0 immediately; req_ready=0.
- **Single requester:** req_valid=3'b010, addr=5, data=0xAB over two cycles -> req_ready=3'b010 each cycle; the next cycle shows wr_en=1, wr_addr=5, wr_data=0xAB; ptr=1.
- **Round robin:** all three valid continuously after reset -> grants 0,1,2,0,1,2. wr_addr sequence matches, delayed one cycle.
- **Zero register:** requester 2 writes addr=31 -> transfer occurs, wr_en=0 next cycle, wr_addr/wr_data unchanged, drop_count 0->1. After 300 such writes drop_count=255.
- **Stall:** all valid with ptr=0 and wr_stall=1 for 3 cycles -> req_ready=0 and wr_en=0 during those cycles; on release requester 1 is granted first.
- **Partial contention:** req_valid=3'b101 with ptr=0 -> grant 2, then 0, then 2. Requester 1 is never granted.
